// File: rtl/module_captura_operandos_pkg.sv
// Shared definitions for the calculator operand-entry front end:
// keypad codes, capture FSM states and default operand width.
package pkg_calc;

  localparam int ANCHO_DEF = 8;

  localparam logic [3:0] TECLA_SIGNO = 4'hA;
  localparam logic [3:0] TECLA_ENTER = 4'hB;
  localparam logic [3:0] TECLA_CLEAR = 4'hC;

  typedef enum logic [1:0] {
    ENT_1,
    ENT_2,
    LISTO
  } estado_cap_t;

endpackage

// File: rtl/module_captura_operandos_if.sv
// Keypad-in / operands-out bundle between the operand capture block (master)
// and the selector/display side that consumes the operands (slave).
interface module_captura_operandos_if
  import pkg_calc::*;
#(
  parameter int ANCHO = ANCHO_DEF
);

  logic             tecla_valida;
  logic [3:0]       tecla;
  logic [ANCHO-1:0] num_1;
  logic             sig_1;
  logic             listo_1;
  logic [ANCHO-1:0] num_2;
  logic             sig_2;
  logic             listo_2;
  logic             ini_mul;
  logic [ANCHO-1:0] num_act;
  logic             sig_act;
  logic             error;

  modport master (
    input  tecla_valida, tecla,
    output num_1, sig_1, listo_1, num_2, sig_2, listo_2,
           ini_mul, num_act, sig_act, error
  );

  modport slave (
    output tecla_valida, tecla,
    input  num_1, sig_1, listo_1, num_2, sig_2, listo_2,
           ini_mul, num_act, sig_act, error
  );

endinterface

// File: rtl/module_captura_operandos_acum.sv
// Decimal accumulator for the operand being typed: value, digit count,
// working sign and the "does one more digit fit" check.
module module_acum_dec
  import pkg_calc::*;
#(
  parameter int ANCHO   = ANCHO_DEF,
  parameter int MAX_DIG = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             carga,
  input  logic             tog,
  input  logic [3:0]       dig,
  output logic [ANCHO-1:0] acc,
  output logic             sig,
  output logic             dig_ok,
  output logic             vacio
);

  localparam int CNT_W = $clog2(MAX_DIG + 1);

  logic [CNT_W-1:0] cnt;
  logic [ANCHO+3:0] cand;

  function automatic logic [ANCHO+3:0] candidato(input logic [ANCHO-1:0] a,
                                                 input logic [3:0]       d);
    return ({4'b0000, a} * (ANCHO+4)'(10)) + (ANCHO+4)'(d);
  endfunction

  // Four extra bits always hold acc*10+9, so overflow is any bit above ANCHO.
  function automatic logic cabe(input logic [ANCHO+3:0] c);
    return (c[ANCHO+3:ANCHO] == 4'b0000);
  endfunction

  assign cand   = candidato(acc, dig);
  assign dig_ok = (cnt != CNT_W'(MAX_DIG)) && cabe(cand);
  assign vacio  = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      sig <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      sig <= 1'b0;
      cnt <= '0;
    end else begin
      if (carga) begin
        acc <= cand[ANCHO-1:0];
        cnt <= cnt + CNT_W'(1);
      end
      if (tog) sig <= ~sig;
    end
  end

endmodule

// File: rtl/module_captura_operandos.sv
// Operand capture front end: decodes keypad strobes, builds two sign-magnitude
// operands and signals the multiplier once both are committed.
module module_captura_operandos
  import pkg_calc::*;
#(
  parameter int ANCHO   = ANCHO_DEF,
  parameter int MAX_DIG = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  module_captura_operandos_if.master bus
);

  estado_cap_t      estado, estado_sig;
  logic             carga, tog, clr_acc, limpiar, commit_1, commit_2, rechazo;
  logic [ANCHO-1:0] acc;
  logic             sig_w, dig_ok, vacio;
  logic [ANCHO-1:0] num_1_q, num_2_q;
  logic             sig_1_q, sig_2_q, listo_1_q, listo_2_q, listo_2_d;
  logic             ini_q, err_q;

  module_acum_dec #(.ANCHO(ANCHO), .MAX_DIG(MAX_DIG)) u_acum (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_acc),
    .carga  (carga),
    .tog    (tog),
    .dig    (bus.tecla),
    .acc    (acc),
    .sig    (sig_w),
    .dig_ok (dig_ok),
    .vacio  (vacio)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado <= ENT_1;
    else      estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    carga      = 1'b0;
    tog        = 1'b0;
    clr_acc    = 1'b0;
    limpiar    = 1'b0;
    commit_1   = 1'b0;
    commit_2   = 1'b0;
    rechazo    = 1'b0;
    if (bus.tecla_valida) begin
      if (bus.tecla == TECLA_CLEAR) begin
        limpiar    = 1'b1;
        clr_acc    = 1'b1;
        estado_sig = ENT_1;
      end else if (estado != LISTO) begin
        if (bus.tecla <= 4'd9) begin
          carga   = dig_ok;
          rechazo = ~dig_ok;
        end else if (bus.tecla == TECLA_SIGNO) begin
          tog = 1'b1;
        end else if (bus.tecla == TECLA_ENTER) begin
          if (vacio) begin
            rechazo = 1'b1;
          end else begin
            clr_acc = 1'b1;
            if (estado == ENT_1) begin
              commit_1   = 1'b1;
              estado_sig = ENT_2;
            end else begin
              commit_2   = 1'b1;
              estado_sig = LISTO;
            end
          end
        end
      end
    end
  end

  // Commit registers and output pulses; a zero magnitude never keeps a sign.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_1_q   <= '0;
      sig_1_q   <= 1'b0;
      listo_1_q <= 1'b0;
      num_2_q   <= '0;
      sig_2_q   <= 1'b0;
      listo_2_q <= 1'b0;
      listo_2_d <= 1'b0;
      ini_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (limpiar) begin
      num_1_q   <= '0;
      sig_1_q   <= 1'b0;
      listo_1_q <= 1'b0;
      num_2_q   <= '0;
      sig_2_q   <= 1'b0;
      listo_2_q <= 1'b0;
      listo_2_d <= 1'b0;
      ini_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (commit_1) begin
        num_1_q   <= acc;
        sig_1_q   <= sig_w & (acc != '0);
        listo_1_q <= 1'b1;
      end
      if (commit_2) begin
        num_2_q   <= acc;
        sig_2_q   <= sig_w & (acc != '0);
        listo_2_q <= 1'b1;
      end
      listo_2_d <= listo_2_q;
      ini_q     <= listo_2_q & ~listo_2_d;
      err_q     <= rechazo;
    end
  end

  assign bus.num_1   = num_1_q;
  assign bus.sig_1   = sig_1_q;
  assign bus.listo_1 = listo_1_q;
  assign bus.num_2   = num_2_q;
  assign bus.sig_2   = sig_2_q;
  assign bus.listo_2 = listo_2_q;
  assign bus.ini_mul = ini_q;
  assign bus.num_act = acc;
  assign bus.sig_act = sig_w;
  assign bus.error   = err_q;

endmodule

// File: tb/tb_module_captura_operandos.sv
// Bench for module_captura_operandos: directed key table, ini_mul timing,
// async reset mid-entry and randomized keys against a behavioural model.
module tb_module_captura_operandos;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  module_captura_operandos_if bus ();

  module_captura_operandos dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] k;
    int act; bit sa; bit err;
    bit l1; int n1; bit s1;
    bit l2; int n2; bit s2;
  } vec_t;

  vec_t tbl[$];

  // Reference model: operands as plain integers, phase 0/1/2 = op1, op2, done.
  int m_ph, m_acc, m_cnt, m_n1, m_n2;
  bit m_sg, m_s1, m_s2, m_l1, m_l2, m_err, m_ini, m_pend;

  function automatic vec_t mk(logic [3:0] k, int act, bit sa, bit err,
                              bit l1, int n1, bit s1, bit l2, int n2, bit s2);
    vec_t v;
    v.k = k; v.act = act; v.sa = sa; v.err = err;
    v.l1 = l1; v.n1 = n1; v.s1 = s1; v.l2 = l2; v.n2 = n2; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_acc = 0; m_cnt = 0; m_n1 = 0; m_n2 = 0;
    m_sg = 0; m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0;
    m_err = 0; m_ini = 0; m_pend = 0;
  endtask

  task automatic m_step(bit v, logic [3:0] k);
    int c;
    m_ini  = m_pend;
    m_pend = 0;
    m_err  = 0;
    if (v) begin
      if (k == 4'hC) begin
        m_reset();
      end else if (m_ph != 2) begin
        if (k <= 4'd9) begin
          c = m_acc * 10 + int'(k);
          if (m_cnt == 3 || c > 255) m_err = 1;
          else begin m_acc = c; m_cnt++; end
        end else if (k == 4'hA) begin
          m_sg = !m_sg;
        end else if (k == 4'hB) begin
          if (m_cnt == 0) m_err = 1;
          else begin
            if (m_ph == 0) begin
              m_n1 = m_acc; m_s1 = m_sg && (m_acc != 0); m_l1 = 1; m_ph = 1;
            end else begin
              m_n2 = m_acc; m_s2 = m_sg && (m_acc != 0); m_l2 = 1; m_ph = 2;
              m_pend = 1;
            end
            m_acc = 0; m_cnt = 0; m_sg = 0;
          end
        end
      end
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, " num_act"}, bus.num_act, m_acc);
    chk({tag, " sig_act"}, bus.sig_act, m_sg);
    chk({tag, " num_1"},   bus.num_1,   m_n1);
    chk({tag, " sig_1"},   bus.sig_1,   m_s1);
    chk({tag, " listo_1"}, bus.listo_1, m_l1);
    chk({tag, " num_2"},   bus.num_2,   m_n2);
    chk({tag, " sig_2"},   bus.sig_2,   m_s2);
    chk({tag, " listo_2"}, bus.listo_2, m_l2);
    chk({tag, " ini_mul"}, bus.ini_mul, m_ini);
    chk({tag, " error"},   bus.error,   m_err);
  endtask

  task automatic press(logic [3:0] k);
    @(negedge clk);
    bus.tecla_valida = 1'b1;
    bus.tecla        = k;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
  endtask

  initial begin
    logic [3:0] k;
    bit         v;
    int         r;

    bus.tecla_valida = 1'b0;
    bus.tecla        = 4'h0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    chk_model("reset");
    rst = 1'b1;

    // Directed table: key, act, sa, err, l1, n1, s1, l2, n2, s2
    tbl.push_back(mk(4'h1,   1, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h5,  15, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hB,   0, 0, 0, 1,  15, 0, 0,  0, 0));
    tbl.push_back(mk(4'hA,   0, 1, 0, 1,  15, 0, 0,  0, 0));
    tbl.push_back(mk(4'h1,   1, 1, 0, 1,  15, 0, 0,  0, 0));
    tbl.push_back(mk(4'h0,  10, 1, 0, 1,  15, 0, 0,  0, 0));
    tbl.push_back(mk(4'hB,   0, 0, 0, 1,  15, 0, 1, 10, 1));
    tbl.push_back(mk(4'h7,   0, 0, 0, 1,  15, 0, 1, 10, 1));
    tbl.push_back(mk(4'hB,   0, 0, 0, 1,  15, 0, 1, 10, 1));
    tbl.push_back(mk(4'hC,   0, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h2,   2, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h5,  25, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h5, 255, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hB,   0, 0, 0, 1, 255, 0, 0,  0, 0));
    tbl.push_back(mk(4'h2,   2, 0, 0, 1, 255, 0, 0,  0, 0));
    tbl.push_back(mk(4'h5,  25, 0, 0, 1, 255, 0, 0,  0, 0));
    tbl.push_back(mk(4'h6,  25, 0, 1, 1, 255, 0, 0,  0, 0));
    tbl.push_back(mk(4'hE,  25, 0, 0, 1, 255, 0, 0,  0, 0));
    tbl.push_back(mk(4'hC,   0, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h1,   1, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h2,  12, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h3, 123, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h4, 123, 0, 1, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hB,   0, 0, 0, 1, 123, 0, 0,  0, 0));
    tbl.push_back(mk(4'hC,   0, 0, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hB,   0, 0, 1, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hA,   0, 1, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'h0,   0, 1, 0, 0,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hB,   0, 0, 0, 1,   0, 0, 0,  0, 0));
    tbl.push_back(mk(4'hC,   0, 0, 0, 0,   0, 0, 0,  0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.tecla_valida = 1'b1;
      bus.tecla        = tbl[i].k;
      @(negedge clk);
      bus.tecla_valida = 1'b0;
      chk($sformatf("tbl%0d num_act", i), bus.num_act, tbl[i].act);
      chk($sformatf("tbl%0d sig_act", i), bus.sig_act, tbl[i].sa);
      chk($sformatf("tbl%0d error",   i), bus.error,   tbl[i].err);
      chk($sformatf("tbl%0d listo_1", i), bus.listo_1, tbl[i].l1);
      chk($sformatf("tbl%0d num_1",   i), bus.num_1,   tbl[i].n1);
      chk($sformatf("tbl%0d sig_1",   i), bus.sig_1,   tbl[i].s1);
      chk($sformatf("tbl%0d listo_2", i), bus.listo_2, tbl[i].l2);
      chk($sformatf("tbl%0d num_2",   i), bus.num_2,   tbl[i].n2);
      chk($sformatf("tbl%0d sig_2",   i), bus.sig_2,   tbl[i].s2);
    end

    // ini_mul: low when listo_2 rises, high the next cycle, low after that.
    press(4'h1); press(4'hB); press(4'h2); press(4'hB);
    chk("ini seq listo_2", bus.listo_2, 1);
    chk("ini seq t0", bus.ini_mul, 0);
    @(negedge clk);
    chk("ini seq t1", bus.ini_mul, 1);
    @(negedge clk);
    chk("ini seq t2", bus.ini_mul, 0);
    repeat (3) @(negedge clk);
    chk("ini seq hold", bus.ini_mul, 0);
    chk("ini seq num_2", bus.num_2, 2);
    press(4'hC);

    // Async reset in the middle of a cycle, after operand 1 and two digits.
    press(4'h1); press(4'hB); press(4'h4); press(4'h2);
    chk("arst pre num_act", bus.num_act, 42);
    #2 rst = 1'b0;
    #1;
    chk("arst num_act", bus.num_act, 0);
    chk("arst listo_1", bus.listo_1, 0);
    chk("arst num_1", bus.num_1, 0);
    @(negedge clk);
    rst = 1'b1;
    press(4'h3); press(4'hB);
    chk("arst restart num_1", bus.num_1, 3);
    chk("arst restart listo_1", bus.listo_1, 1);
    chk("arst restart listo_2", bus.listo_2, 0);
    press(4'hC);

    // Randomized keys against the model, back-to-back strobes allowed.
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 68) k = 4'hA;
      else if (r < 88) k = 4'hB;
      else if (r < 92) k = 4'hC;
      else             k = 4'($urandom_range(13, 15));
      bus.tecla_valida = v;
      bus.tecla        = k;
      m_step(v, k);
      @(negedge clk);
      chk_model($sformatf("rnd%0d", i));
    end
    bus.tecla_valida = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/module_captura_operandos.md
Name: module_captura_operandos

Overview:
- Operand-entry front end of the calculator datapath.
- Takes debounced keypad codes and assembles two 8-bit sign-magnitude decimal operands.
- Presents them as num_1/sig_1/listo_1 and num_2/sig_2/listo_2, with a one-cycle start pulse for the multiplier.
- It is the producer side of the operand/ready interface that the priority/display selector consumes.

Parameters:
- ANCHO, 8, operand magnitude width in bits.
- MAX_DIG, 3, maximum decimal digits accepted per operand.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tecla_valida  input  1  one-cycle strobe: tecla is valid this cycle.
- tecla  input  4  key code: 0-9 digit, 4'hA sign toggle, 4'hB enter, 4'hC clear, others ignored.
- num_1  output  ANCHO  latched magnitude of operand 1.
- sig_1  output  1  sign of operand 1 (1 = negative).
- listo_1  output  1  level: operand 1 committed.
- num_2  output  ANCHO  latched magnitude of operand 2.
- sig_2  output  1  sign of operand 2.
- listo_2  output  1  level: operand 2 committed.
- ini_mul  output  1  one-cycle pulse, the cycle after listo_2 rises.
- num_act  output  ANCHO  magnitude currently being typed (live echo for display).
- sig_act  output  1  sign currently being typed.
- error  output  1  one-cycle pulse: a key was rejected.

Behaviour:
- Reset (rst = 0, async):
  - State goes to ENT_1.
  - All outputs and internal accumulators go to 0: num_1, num_2, num_act = 0; sig_* = 0; listo_* = 0; ini_mul = 0; error = 0.
  - Digit count goes to 0.
- Keys are processed only on cycles with tecla_valida = 1. Each key updates registers on that edge, so outputs change 1 cycle after the strobe.
- States:
  - ENT_1: building operand 1.
  - ENT_2: building operand 2.
  - LISTO: both committed, waiting for clear.
- Digit d in ENT_1 or ENT_2:
  - Candidate value is acc*10 + d, computed at ANCHO+4 bits.
  - If digit count = MAX_DIG or candidate > 2^ANCHO-1: the key is ignored and error pulses.
  - Otherwise acc <= candidate and the digit count increments.
  - Leading zeros count as digits.
- Sign key (4'hA) in ENT_1 or ENT_2 toggles the working sign. It is allowed at any point before enter.
- Enter key (4'hB):
  - With digit count = 0: ignored, error pulses.
  - In ENT_1: num_1 <= acc, sig_1 <= sign & (acc != 0), listo_1 <= 1. Accumulator, sign and count clear. Next state ENT_2.
  - In ENT_2: same commit into num_2/sig_2/listo_2. Next state LISTO. ini_mul = 1 on the following cycle only.
- Negative zero is normalised: a committed magnitude of 0 always gets sign 0.
- Clear key (4'hC) in any state: same effect as reset, except it is synchronous. Clear takes effect even mid-entry.
- In LISTO:
  - Digit, sign and enter keys are ignored, with no error pulse.
  - num_1, num_2, sig_1, sig_2, listo_1 and listo_2 hold their values.
- num_act/sig_act mirror the accumulator and working sign. They read 0 after each commit and in LISTO.
- listo_1 and listo_2 are levels and stay high until clear or reset. ini_mul is never asserted for more than 1 cycle.
- Invalid codes (4'hD-4'hF) are ignored silently.
- An async reset asserted during a strobe overrides everything.

Decomposition:
- Package pkg_calc holds:
  - Key code constants: TECLA_SIGNO = 4'hA, TECLA_ENTER = 4'hB, TECLA_CLEAR = 4'hC.
  - Enum estado_cap_t {ENT_1, ENT_2, LISTO}.
  - Default ANCHO.
- Sub-module module_acum_dec holds the accumulator, digit counter, working sign, overflow check and the clear/load controls.
- The top level holds the FSM, the commit registers and the ini_mul/error pulse logic.

Test Plan:
- Keys 1,5,B then A,1,0,B -> num_1=15 sig_1=0 listo_1=1; num_2=10 sig_2=1 listo_2=1; ini_mul high exactly 1 cycle after listo_2 rises.
- Keys 2,5,5,B -> num_1=255. Keys 2,5,6 -> 6 rejected, error pulses once, num_act stays 25.
- Keys 1,2,3,4 -> 4th digit rejected with an error pulse; then B commits num_1=123.
- B with no digits -> error pulse, state stays ENT_1. Keys A,0,B -> num_1=0 sig_1=0 (negative zero normalised).
- In LISTO, keys 7,B -> no output change and no error. Then key C -> all outputs 0, state ENT_1.
- Pull rst low mid-entry after keys 4,2 -> num_act=0 and listo_*=0 immediately, without waiting for a clock edge; entry restarts cleanly after rst returns high.
